cd_spi_slave: RTL and testbench



---
 rtl/cd_spi_pkg.sv | 14 +
 rtl/cd_sync.sv | 24 ++
 rtl/cd_spi_slave.sv | 131 +++++++++++++
 tb/tb_cd_spi_slave.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cd_spi_pkg.sv
// rtl/cd_spi_pkg.sv - shared types and constants for the CDBUS SPI slave bridge
package cd_spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_WDATA = 2'd2,
        ST_RDATA = 2'd3
    } spi_state_e;

    localparam int CMD_WR_BIT     = 7;
    localparam int DEFAULT_ADDR_W = 5;

endpackage

// File: rtl/cd_sync.sv
// rtl/cd_sync.sv - multi-stage flip-flop synchronizer for one asynchronous input
module cd_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    // Resetting low keeps a still-low NSS from looking like a fresh fall after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/cd_spi_slave.sv
// rtl/cd_spi_slave.sv - oversampled SPI mode-0 slave bridging to the CDBUS CSR bus
module cd_spi_slave
    import cd_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              spi_sck,
    input  logic              spi_nss,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic              chip_select,
    output logic [ADDR_W-1:0] csr_address,
    output logic              csr_read,
    input  logic [7:0]        csr_readdata,
    output logic              csr_write,
    output logic [7:0]        csr_writedata
);

    logic sck_s, nss_s, mosi_s;
    logic sck_d, nss_d;
    logic sck_rise, sck_fall, nss_rise, nss_fall;

    cd_sync #(.STAGES(SYNC_STAGES)) u_sync_sck  (.clk(clk), .reset_n(reset_n), .d(spi_sck),  .q(sck_s));
    cd_sync #(.STAGES(SYNC_STAGES)) u_sync_nss  (.clk(clk), .reset_n(reset_n), .d(spi_nss),  .q(nss_s));
    cd_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (.clk(clk), .reset_n(reset_n), .d(spi_mosi), .q(mosi_s));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_d <= 1'b0;
            nss_d <= 1'b0;
        end else begin
            sck_d <= sck_s;
            nss_d <= nss_s;
        end
    end

    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign nss_rise = nss_s & ~nss_d;
    assign nss_fall = ~nss_s & nss_d;

    spi_state_e state, state_next;
    logic [2:0] bit_cnt;
    logic [7:0] rx_sr, tx_sr, rx_byte;
    logic       byte_done, wr_req, rd_req, addr_load;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        wr_req     = 1'b0;
        rd_req     = 1'b0;
        addr_load  = 1'b0;
        rx_byte    = {rx_sr[6:0], mosi_s};
        byte_done  = sck_rise && (bit_cnt == 3'd7);
        case (state)
            ST_IDLE: begin
                if (nss_fall) state_next = ST_CMD;
            end
            ST_CMD: begin
                if (byte_done) begin
                    addr_load = 1'b1;
                    if (rx_byte[CMD_WR_BIT]) begin
                        state_next = ST_WDATA;
                    end else begin
                        state_next = ST_RDATA;
                        rd_req     = 1'b1;
                    end
                end
            end
            ST_WDATA: begin
                if (byte_done) wr_req = 1'b1;
            end
            ST_RDATA: begin
                if (byte_done) rd_req = 1'b1;
            end
            default: state_next = ST_IDLE;
        endcase
        // Deselect wins over a byte completing in the same cycle.
        if (nss_rise) begin
            state_next = ST_IDLE;
            wr_req     = 1'b0;
            rd_req     = 1'b0;
            addr_load  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt       <= 3'd0;
            rx_sr         <= 8'h00;
            tx_sr         <= 8'h00;
            csr_address   <= '0;
            csr_read      <= 1'b0;
            csr_write     <= 1'b0;
            csr_writedata <= 8'h00;
        end else begin
            csr_read  <= rd_req;
            csr_write <= wr_req;
            if (wr_req)    csr_writedata <= rx_byte;
            if (addr_load) csr_address   <= rx_byte[ADDR_W-1:0];
            if (state == ST_IDLE || state_next == ST_IDLE) begin
                bit_cnt <= 3'd0;
            end else if (sck_rise) begin
                bit_cnt <= bit_cnt + 3'd1;
                rx_sr   <= rx_byte;
            end
            // The fall right after a byte boundary must not shift away the freshly loaded MSB.
            if (csr_read) begin
                tx_sr <= csr_readdata;
            end else if (state == ST_RDATA && sck_fall && bit_cnt != 3'd0) begin
                tx_sr <= {tx_sr[6:0], 1'b0};
            end
        end
    end

    assign chip_select = (state != ST_IDLE);
    assign spi_miso_oe = chip_select;
    assign spi_miso    = (state == ST_RDATA) && tx_sr[7];

endmodule

// File: tb/tb_cd_spi_slave.sv
// tb/tb_cd_spi_slave.sv - table-driven self-checking bench for cd_spi_slave
`timescale 1ns/1ps
module tb_cd_spi_slave;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       spi_sck, spi_nss, spi_mosi;
    logic       spi_miso, spi_miso_oe, chip_select;
    logic [4:0] csr_address;
    logic       csr_read, csr_write;
    logic [7:0] csr_readdata, csr_writedata;

    cd_spi_slave #(.SYNC_STAGES(2), .ADDR_W(5)) dut (
        .clk(clk), .reset_n(reset_n),
        .spi_sck(spi_sck), .spi_nss(spi_nss), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .chip_select(chip_select),
        .csr_address(csr_address), .csr_read(csr_read), .csr_readdata(csr_readdata),
        .csr_write(csr_write), .csr_writedata(csr_writedata)
    );

    always #12.5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int rd_idx = 0;
    int proto_err = 0;
    int cs_err = 0;
    bit cs_watch = 0;
    bit prev_wr = 0, prev_rd = 0;
    logic [7:0] wr_data [$];
    logic [4:0] wr_addr [$];
    logic [4:0] rd_addr [$];
    logic [7:0] miso_got [4];

    // Register-file read model: successive reads return 0x11, 0x22, 0x33, 0x44 ...
    assign csr_readdata = 8'((rd_idx + 1) * 17);

    always @(negedge clk) begin
        if (reset_n) begin
            if (csr_write) begin
                wr_addr.push_back(csr_address);
                wr_data.push_back(csr_writedata);
            end
            if (csr_read) rd_addr.push_back(csr_address);
            if (csr_write && csr_read) proto_err++;
            if ((csr_write && prev_wr) || (csr_read && prev_rd)) proto_err++;
            if (prev_rd) rd_idx++;
            prev_wr = csr_write;
            prev_rd = csr_read;
            if (cs_watch && (chip_select || spi_miso_oe)) cs_err++;
        end else begin
            prev_wr = 0;
            prev_rd = 0;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic clear_logs();
        wr_data.delete();
        wr_addr.delete();
        rd_addr.delete();
        rd_idx = 0;
    endtask

    task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = tx[7-i];
            #100;
            spi_sck = 1'b1;
            rx[7-i] = spi_miso;
            #100;
            spi_sck = 1'b0;
        end
    endtask

    task automatic run_txn(input logic [7:0] cmd, input int nb, input logic [23:0] wd);
        logic [7:0] r;
        spi_nss = 1'b0;
        #200;
        spi_xfer(cmd, 8, r);
        miso_got[0] = r;
        for (int b = 0; b < nb; b++) begin
            spi_xfer(wd[23-8*b -: 8], 8, r);
            miso_got[b+1] = r;
        end
        #100;
        spi_nss = 1'b1;
        #300;
    endtask

    typedef struct {
        logic [7:0]  cmd;
        int          nb;
        logic [23:0] wd;
        int          n_wr;
        int          n_rd;
        logic [4:0]  addr;
        logic [31:0] miso;
    } vec_t;

    vec_t vecs [5];

    initial begin
        logic [7:0] dummy;
        logic [31:0] got;
        vecs[0] = '{8'h9B, 1, 24'h5A0000, 1, 0, 5'h1B, 32'h00000000};
        vecs[1] = '{8'h14, 3, 24'h000000, 0, 4, 5'h14, 32'h00112233};
        vecs[2] = '{8'h95, 3, 24'h010203, 3, 0, 5'h15, 32'h00000000};
        vecs[3] = '{8'hE7, 1, 24'hC30000, 1, 0, 5'h07, 32'h00000000};
        vecs[4] = '{8'h03, 1, 24'hA50000, 0, 2, 5'h03, 32'h00110000};

        reset_n  = 1'b0;
        spi_sck  = 1'b0;
        spi_nss  = 1'b1;
        spi_mosi = 1'b0;
        #60;
        check("rst_cs", 32'(chip_select), 0);
        check("rst_oe", 32'(spi_miso_oe), 0);
        check("rst_miso", 32'(spi_miso), 0);
        check("rst_addr", 32'(csr_address), 0);
        check("rst_rd", 32'(csr_read), 0);
        check("rst_wr", 32'(csr_write), 0);
        check("rst_wdata", 32'(csr_writedata), 0);
        reset_n = 1'b1;
        #200;

        foreach (vecs[v]) begin
            clear_logs();
            run_txn(vecs[v].cmd, vecs[v].nb, vecs[v].wd);
            check($sformatf("v%0d_nwr", v), 32'(wr_data.size()), 32'(vecs[v].n_wr));
            check($sformatf("v%0d_nrd", v), 32'(rd_addr.size()), 32'(vecs[v].n_rd));
            for (int i = 0; i < vecs[v].n_wr; i++) begin
                got = (i < wr_data.size()) ? 32'(wr_data[i]) : 32'hDEAD;
                check($sformatf("v%0d_wdata%0d", v, i), got, 32'(vecs[v].wd[23-8*i -: 8]));
                got = (i < wr_addr.size()) ? 32'(wr_addr[i]) : 32'hDEAD;
                check($sformatf("v%0d_waddr%0d", v, i), got, 32'(vecs[v].addr));
            end
            for (int i = 0; i < vecs[v].n_rd; i++) begin
                got = (i < rd_addr.size()) ? 32'(rd_addr[i]) : 32'hDEAD;
                check($sformatf("v%0d_raddr%0d", v, i), got, 32'(vecs[v].addr));
            end
            for (int b = 0; b <= vecs[v].nb; b++)
                check($sformatf("v%0d_miso%0d", v, b), 32'(miso_got[b]), 32'(vecs[v].miso[31-8*b -: 8]));
            check($sformatf("v%0d_addr_hold", v), 32'(csr_address), 32'(vecs[v].addr));
            check($sformatf("v%0d_cs_off", v), 32'(chip_select), 0);
        end

        // Partial data byte on deselect: no write, next transaction still decodes.
        clear_logs();
        spi_nss = 1'b0;
        #200;
        spi_xfer(8'h9B, 8, dummy);
        spi_xfer(8'hFF, 5, dummy);
        #100;
        spi_nss = 1'b1;
        #300;
        check("part_nwr", 32'(wr_data.size()), 0);
        check("part_cs", 32'(chip_select), 0);
        check("part_addr", 32'(csr_address), 32'h1B);
        run_txn(8'h81, 1, 24'h770000);
        check("part_next_nwr", 32'(wr_data.size()), 1);
        got = (wr_data.size() > 0) ? 32'(wr_data[0]) : 32'hDEAD;
        check("part_next_wdata", got, 32'h77);
        check("part_next_addr", 32'(csr_address), 32'h01);

        // Reset pulse in the middle of a read.
        clear_logs();
        spi_nss = 1'b0;
        #200;
        spi_xfer(8'h14, 8, dummy);
        spi_xfer(8'h00, 4, dummy);
        check("mid_rd_prefetch", 32'(rd_addr.size()), 1);
        #50;
        reset_n = 1'b0;
        #1;
        check("mrst_cs", 32'(chip_select), 0);
        check("mrst_oe", 32'(spi_miso_oe), 0);
        check("mrst_miso", 32'(spi_miso), 0);
        check("mrst_addr", 32'(csr_address), 0);
        check("mrst_wdata", 32'(csr_writedata), 0);
        check("mrst_strobes", 32'({csr_read, csr_write}), 0);
        #100;
        reset_n = 1'b1;
        clear_logs();
        spi_xfer(8'hFF, 8, dummy);
        spi_xfer(8'h8F, 8, dummy);
        check("post_rst_nwr", 32'(wr_data.size()), 0);
        check("post_rst_nrd", 32'(rd_addr.size()), 0);
        check("post_rst_cs", 32'(chip_select), 0);
        spi_nss = 1'b1;
        #300;
        run_txn(8'h8A, 1, 24'h3C0000);
        got = (wr_data.size() > 0) ? 32'(wr_data[0]) : 32'hDEAD;
        check("post_rst_txn_wdata", got, 32'h3C);
        check("post_rst_txn_addr", 32'(csr_address), 32'h0A);

        // SCK activity with NSS inactive is ignored.
        clear_logs();
        cs_watch = 1;
        spi_xfer(8'hA5, 8, dummy);
        spi_xfer(8'h14, 8, dummy);
        #200;
        cs_watch = 0;
        check("idle_sck_nwr", 32'(wr_data.size()), 0);
        check("idle_sck_nrd", 32'(rd_addr.size()), 0);
        check("idle_sck_cs", 32'(cs_err), 0);

        check("strobe_protocol", 32'(proto_err), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
